dpi_stream_sequencer: RTL and testbench
=======================================

# dpi_stream_sequencer

Upstream front end of the packet-inspection regex bank. Accepts a byte-wide packet stream tagged with a flow key and maps each key to a 6-bit stream slot in a 64-entry table. It drives the per-matcher control protocol for every packet: `load_state`, gated characters, then `eop`. Cycle gaps are inserted so matcher state is restored before the first character and saved after the last.

## Interface
- `KEY_W`, 16: flow key width.
- `LOAD_GAP`, 2: idle cycles between the `load_state` pulse and the first forwarded character (≥2).
- `EOP_GAP`, 3: idle cycles between the last forwarded character and the `eop` pulse (≥3).

- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_data` in 8: packet byte.
- `in_valid` in 1: `in_data` / `in_sop` / `in_eop` / `in_flow_key` valid.
- `in_sop` in 1: first byte of packet.
- `in_eop` in 1: last byte of packet.
- `in_flow_key` in KEY_W: flow key, meaningful when `in_valid & in_sop`.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `flush` in 1: pulse; invalidate all table entries.
- `char_in` out 8: byte to matchers.
- `char_in_vld` out 1: `char_in` valid.
- `load_state` out 1: one-cycle pulse; matchers restore state.
- `stream_id` out 6: slot for current packet.
- `new_stream_id` out 1: slot freshly allocated; matchers load zero state.
- `enable` out 1: packet inspected; matchers commit at `eop`.
- `eop` out 1: one-cycle pulse; matchers finalize count and save state.
- `drop_count` out 16: packets seen with table full (saturating).
- `err_count` out 16: non-SOP beats discarded in IDLE (saturating).

## Operation
- Table: 64 entries of {`valid`, `key[KEY_W-1:0]`}. Lookup is a parallel compare of all 64 entries.
- FSM states: IDLE, LOOKUP, LOAD, WAIT, STREAM, DRAIN, EOP.
- IDLE, `in_valid & in_sop`:
  - Capture `in_flow_key`; do not consume the beat (`in_ready=0`).
  - Go to LOOKUP.
- IDLE, `in_valid & ~in_sop`:
  - `in_ready=1`; beat discarded; `err_count` increments.
- LOOKUP (1 cycle), registered result:
  - Hit at index i: `stream_id=i`, `new_stream_id=0`, `enable=1`.
  - Miss with free entry: allocate lowest free index j; set valid and key; `stream_id=j`, `new_stream_id=1`, `enable=1`.
  - Miss with table full: `stream_id=0`, `new_stream_id=0`, `enable=0`; `drop_count` increments.
- LOAD: `load_state=1` for exactly one cycle.
- WAIT: LOAD_GAP cycles, then STREAM.
- STREAM:
  - `in_ready=1`.
  - Each accepted beat: next cycle `char_in=in_data`, `char_in_vld=1`.
  - When `in_valid=0`, `char_in_vld=0` next cycle.
  - Accepted beat with `in_eop` → DRAIN.
  - `in_sop` inside STREAM is treated as data; no new packet starts.
- DRAIN: EOP_GAP cycles with `char_in_vld=0`.
- EOP: `eop=1` for one cycle, then IDLE.
- `stream_id`, `new_stream_id` and `enable` are held constant from LOAD through EOP inclusive.
- Single-byte packet (`in_sop & in_eop` on the same beat): one character is forwarded, then DRAIN.
- `flush`:
  - Asserted in IDLE: all valid bits clear next cycle.
  - Asserted otherwise: latched as pending; applied on entry to IDLE. The current packet completes on its existing slot.
- Counters saturate at 0xFFFF.

## Timing
- Reset values: `in_ready=0`, `char_in=0`, `char_in_vld=0`, `load_state=0`, `eop=0`, `stream_id=0`, `new_stream_id=0`, `enable=0`, counters 0, all table entries invalid, FSM=IDLE.
- Reset mid-packet aborts immediately. No `eop` is issued and the upstream source must restart with SOP.
- SOP seen at cycle T: LOOKUP at T+1, `load_state` at T+2.
- First STREAM cycle (`in_ready=1`) is T+3+LOAD_GAP; the first `char_in_vld` appears one cycle after it is accepted.
- Last byte accepted at cycle E: `char_in_vld` at E+1, `eop` at E+2+EOP_GAP.
- Earliest next SOP detection is the cycle after `eop`, so the next `load_state` follows `eop` by ≥3 cycles. This guarantees the same-slot state save completes before restore.
- Character data latency is one cycle, with no bubbles beyond those in `in_valid`.

## Test plan
- Key 0x1234 into an empty table, 4-byte packet → `load_state` at T+2 with `stream_id=0`, `new_stream_id=1`, `enable=1`; 4 `char_in_vld` cycles carry the bytes in order; `eop` exactly EOP_GAP+1 cycles after the last `char_in_vld`.
- Second packet with key 0x1234, then one with key 0xBEEF → first gives `stream_id=0`, `new_stream_id=0`; second gives `stream_id=1`, `new_stream_id=1`.
- 64 distinct keys, then a 65th new key → 65th packet has `enable=0`, `stream_id=0`, `drop_count=1`; characters still forwarded and `eop` still pulsed.
- `flush` pulsed mid-STREAM → current packet keeps its `stream_id` through `eop`; the next packet with an old key gets `stream_id=0`, `new_stream_id=1`.
- Three non-SOP beats in IDLE → all consumed, `err_count=3`, no `load_state`; single-byte packet with `in_valid` gaps afterward → exactly one `char_in_vld`.
- Assert `rst_n=0` asynchronously during STREAM → all outputs at reset values before the next clock edge; no `eop`; table empty afterward.

Source files
------------

// File: rtl/dpi_stream_sequencer.sv
// rtl/dpi_stream_sequencer.sv - flow-key to stream-slot mapper driving the regex matcher control protocol
module dpi_stream_sequencer #(
    parameter int KEY_W    = 16,
    parameter int LOAD_GAP = 2,
    parameter int EOP_GAP  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [KEY_W-1:0] in_flow_key,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             load_state,
    output logic [5:0]       stream_id,
    output logic             new_stream_id,
    output logic             enable,
    output logic             eop,
    output logic [15:0]      drop_count,
    output logic [15:0]      err_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_LOAD, S_WAIT, S_STREAM, S_DRAIN, S_EOP
    } state_t;

    // DRAIN spans the cycle carrying the final character plus EOP_GAP idle cycles.
    localparam logic [7:0] WAIT_LAST  = 8'(LOAD_GAP - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(EOP_GAP);

    state_t           state, state_nxt;
    logic [7:0]       gap_cnt;
    logic [63:0]      tbl_valid;
    logic [KEY_W-1:0] tbl_key [64];
    logic [KEY_W-1:0] key_q;
    logic             flush_pend;
    logic             hit, free;
    logic [5:0]       hit_idx, free_idx;
    logic             idle_err;
    logic             do_flush;
    logic             alloc;

    // Descending scan so the lowest matching / free index is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = 6'd0;
        free     = 1'b0;
        free_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (tbl_valid[i] && (tbl_key[i] == key_q)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
            if (!tbl_valid[i]) begin
                free     = 1'b1;
                free_idx = 6'(i);
            end
        end
    end

    assign idle_err   = (state == S_IDLE) && in_valid && !in_sop;
    assign in_ready   = (state == S_STREAM) || idle_err;
    assign load_state = (state == S_LOAD);
    assign eop        = (state == S_EOP);
    assign alloc      = (state == S_LOOKUP) && !hit && free;
    // A pending flush lands on the EOP->IDLE edge so the current packet keeps its slot.
    assign do_flush   = ((state == S_IDLE) || (state == S_EOP)) && (flush || flush_pend);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid && in_sop) state_nxt = S_LOOKUP;
            S_LOOKUP: state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_WAIT;
            S_WAIT:   if (gap_cnt == WAIT_LAST) state_nxt = S_STREAM;
            S_STREAM: if (in_valid && in_eop) state_nxt = S_DRAIN;
            S_DRAIN:  if (gap_cnt == DRAIN_LAST) state_nxt = S_EOP;
            S_EOP:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            gap_cnt       <= 8'd0;
            char_in       <= 8'd0;
            char_in_vld   <= 1'b0;
            stream_id     <= 6'd0;
            new_stream_id <= 1'b0;
            enable        <= 1'b0;
            key_q         <= '0;
            flush_pend    <= 1'b0;
            tbl_valid     <= '0;
            drop_count    <= 16'd0;
            err_count     <= 16'd0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state_nxt != state) ? 8'd0 : gap_cnt + 8'd1;

            char_in_vld <= (state == S_STREAM) && in_valid;
            if ((state == S_STREAM) && in_valid) char_in <= in_data;

            if ((state == S_IDLE) && in_valid && in_sop) key_q <= in_flow_key;

            if (idle_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;

            if (state == S_LOOKUP) begin
                if (hit) begin
                    stream_id     <= hit_idx;
                    new_stream_id <= 1'b0;
                    enable        <= 1'b1;
                end else if (free) begin
                    tbl_valid[free_idx] <= 1'b1;
                    stream_id           <= free_idx;
                    new_stream_id       <= 1'b1;
                    enable              <= 1'b1;
                end else begin
                    stream_id     <= 6'd0;
                    new_stream_id <= 1'b0;
                    enable        <= 1'b0;
                    if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                end
            end

            if (do_flush) begin
                tbl_valid  <= '0;
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) tbl_key[free_idx] <= key_q;
    end

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb/tb_dpi_stream_sequencer.sv - directed self-checking bench for dpi_stream_sequencer
module tb_dpi_stream_sequencer;

    localparam int LOAD_GAP = 2;
    localparam int EOP_GAP  = 3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid, in_sop, in_eop;
    logic [15:0] in_flow_key;
    logic        in_ready;
    logic        flush;
    logic [7:0]  char_in;
    logic        char_in_vld, load_state, new_stream_id, enable, eop;
    logic [5:0]  stream_id;
    logic [15:0] drop_count, err_count;

    dpi_stream_sequencer #(.KEY_W(16), .LOAD_GAP(LOAD_GAP), .EOP_GAP(EOP_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_flow_key(in_flow_key),
        .in_ready(in_ready), .flush(flush), .char_in(char_in),
        .char_in_vld(char_in_vld), .load_state(load_state), .stream_id(stream_id),
        .new_stream_id(new_stream_id), .enable(enable), .eop(eop),
        .drop_count(drop_count), .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int load_cyc, eop_cyc, first_chr_cyc, last_chr_cyc;
    int n_load = 0, n_eop = 0;
    logic [5:0] ld_sid, eop_sid;
    logic ld_new, ld_en, eop_new, eop_en;
    logic [7:0] chars [$];
    int sop_cyc, acc0, acc_last;

    always @(negedge clk) begin
        if (load_state) begin
            load_cyc = cyc; ld_sid = stream_id; ld_new = new_stream_id; ld_en = enable;
            n_load++;
        end
        if (char_in_vld) begin
            if (chars.size() == 0) first_chr_cyc = cyc;
            chars.push_back(char_in);
            last_chr_cyc = cyc;
        end
        if (eop) begin
            eop_cyc = cyc; eop_sid = stream_id; eop_new = new_stream_id; eop_en = enable;
            n_eop++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_pkt(input logic [15:0] key, input logic [7:0] base, input int n,
                            input bit gaps, input int fl_idx);
        int w;
        int e0;
        chars.delete();
        e0 = n_eop;
        in_flow_key = key;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == n - 1);
            in_data = base + 8'(i); flush = (i == fl_idx);
            w = 0;
            do begin
                @(negedge clk);
                if (i == 0 && w == 0) sop_cyc = cyc;
                w++;
            end while (!in_ready && w < 64);
            if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
            if (i == 0) acc0 = cyc;
            acc_last = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; flush = 1'b0;
            if (gaps) repeat (2) begin @(posedge clk); #1; end
        end
        w = 0;
        do begin @(negedge clk); #1; w++; end while (n_eop == e0 && w < 64);
        if (n_eop == e0) chk("eop_timeout", 32'(n_eop), 32'(e0 + 1));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lc0;
        int e0;
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = 8'h00; in_flow_key = 16'h0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({in_ready, char_in_vld, load_state, eop, new_stream_id, enable}), 32'd0);
        chk("rst_sid_char", 32'({stream_id, char_in}), 32'd0);
        chk("rst_counters", 32'({drop_count, err_count}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First packet: empty table, full timing checks
        send_pkt(16'h1234, 8'hA0, 4, 1'b0, -1);
        chk("p1_load_cyc", 32'(load_cyc), 32'(sop_cyc + 2));
        chk("p1_first_accept", 32'(acc0), 32'(sop_cyc + 3 + LOAD_GAP));
        chk("p1_sid", 32'(ld_sid), 32'd0);
        chk("p1_new", 32'(ld_new), 32'd1);
        chk("p1_en", 32'(ld_en), 32'd1);
        chk("p1_nchars", 32'(chars.size()), 32'd4);
        chk("p1_chars", {chars[0], chars[1], chars[2], chars[3]}, 32'hA0A1A2A3);
        chk("p1_first_chr", 32'(first_chr_cyc), 32'(acc0 + 1));
        chk("p1_last_chr", 32'(last_chr_cyc), 32'(acc_last + 1));
        chk("p1_eop_gap", 32'(eop_cyc - last_chr_cyc), 32'(EOP_GAP + 1));
        chk("p1_eop_hold", 32'({eop_sid, eop_new, eop_en}), 32'({6'd0, 1'b1, 1'b1}));

        // Repeat key (with in_valid gaps) then a new key
        send_pkt(16'h1234, 8'h30, 4, 1'b1, -1);
        chk("p2_sid_new", 32'({ld_sid, ld_new}), 32'({6'd0, 1'b0}));
        chk("p2_nchars", 32'(chars.size()), 32'd4);
        chk("p2_chars", {chars[0], chars[1], chars[2], chars[3]}, 32'h30313233);
        send_pkt(16'hBEEF, 8'h40, 2, 1'b0, -1);
        chk("p3_sid_new", 32'({ld_sid, ld_new, ld_en}), 32'({6'd1, 1'b1, 1'b1}));

        // Fill slots 2..63, then one more key overflows
        for (int i = 2; i < 64; i++) begin
            send_pkt(16'(i + 16'h4000), 8'(i), 1, 1'b0, -1);
            chk("fill_sid", 32'({ld_sid, ld_new}), 32'({6'(i), 1'b1}));
        end
        e0 = n_eop;
        send_pkt(16'hCAFE, 8'h50, 2, 1'b0, -1);
        chk("full_en", 32'(ld_en), 32'd0);
        chk("full_sid_new", 32'({ld_sid, ld_new}), 32'd0);
        chk("full_drop", 32'(drop_count), 32'd1);
        chk("full_chars", {16'(chars.size()), chars[0], chars[1]}, 32'h00025051);
        chk("full_eop", 32'(n_eop), 32'(e0 + 1));

        // Flush mid-stream: current packet keeps slot, table empty afterwards
        send_pkt(16'h1234, 8'h60, 4, 1'b0, 1);
        chk("flush_cur_sid", 32'({ld_sid, ld_new, ld_en}), 32'({6'd0, 1'b0, 1'b1}));
        chk("flush_eop_sid", 32'({eop_sid, eop_new, eop_en}), 32'({6'd0, 1'b0, 1'b1}));
        send_pkt(16'hBEEF, 8'h70, 2, 1'b0, -1);
        chk("post_flush_sid", 32'({ld_sid, ld_new}), 32'({6'd0, 1'b1}));

        // Non-SOP beats in IDLE are consumed and counted
        lc0 = n_load;
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("err_count", 32'(err_count), 32'd3);
        chk("err_no_load", 32'(n_load), 32'(lc0));

        send_pkt(16'h2222, 8'h77, 1, 1'b1, -1);
        chk("single_nchars", 32'(chars.size()), 32'd1);
        chk("single_char", 32'(chars[0]), 32'h77);
        chk("single_sid", 32'({ld_sid, ld_new}), 32'({6'd1, 1'b1}));
        chk("single_eop_gap", 32'(eop_cyc - last_chr_cyc), 32'(EOP_GAP + 1));

        // Asynchronous reset during STREAM
        e0 = n_eop;
        in_flow_key = 16'h1234; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_data = 8'h10;
        w = 0;
        do begin @(negedge clk); w++; end while (!in_ready && w < 64);
        chk("rst_pkt_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_sop = 1'b0; in_data = 8'h11;
        @(posedge clk); #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({in_ready, char_in_vld, load_state, eop, new_stream_id, enable}), 32'd0);
        chk("async_rst_sid_char", 32'({stream_id, char_in}), 32'd0);
        chk("async_rst_counters", 32'({drop_count, err_count}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("async_rst_no_eop", 32'(n_eop), 32'(e0));
        send_pkt(16'h1234, 8'h90, 2, 1'b0, -1);
        chk("post_rst_sid", 32'({ld_sid, ld_new}), 32'({6'd0, 1'b1}));
        send_pkt(16'hBEEF, 8'h91, 1, 1'b0, -1);
        chk("post_rst_sid2", 32'({ld_sid, ld_new}), 32'({6'd1, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
